mdu_ctrl: RTL and testbench

//   Multi-cycle sequencer and HI/LO register owner for the combinational multiply/divide datapath.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu.sv | 51 +++++
 rtl/mdu_ctrl.sv | 130 +++++++++++++
 tb/tb_mdu_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, sequencer states
// and default latencies.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_DIV   = 2'b00,
    MDU_DIVU  = 2'b01,
    MDU_MULT  = 2'b10,
    MDU_MULTU = 2'b11
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int DEF_CNT_W    = 4;

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Combinational multiply/divide datapath. Produces {hi, lo}: product for
// mult/multu, {remainder, quotient} for div/divu.
module mdu
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdu_op_e     op,
  output logic [63:0] result
);

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic [63:0]        a_zext;
  logic [63:0]        b_zext;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign a_sext = {{32{a[31]}}, a};
  assign b_sext = {{32{b[31]}}, b};
  assign a_zext = {32'd0, a};
  assign b_zext = {32'd0, b};
  assign prod_s = a_sext * b_sext;
  assign prod_u = a_zext * b_zext;

  // Signed / and % truncate toward zero; the remainder follows the dividend's sign.
  assign a_s    = a;
  assign b_s    = b;
  assign quot_s = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quot_u = a / b;
  assign rem_u  = a % b;

  always_comb begin
    result = 64'd0;
    case (op)
      MDU_DIV:   result = {rem_s, quot_s};
      MDU_DIVU:  result = {rem_u, quot_u};
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle sequencer and HI/LO owner for the multiply/divide datapath.
// Optional build macro MDU_DIV0_GUARD_EN: divide by zero completes but leaves HI/LO untouched.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter is loaded with LAT-1 so busy spans exactly LAT cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      a_reg, a_next;
  logic [31:0]      b_reg, b_next;
  mdu_op_e          op_reg, op_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic             done_reg, done_next;
  logic [63:0]      result;
  logic             commit_ok;

  mdu u_mdu (
    .a      (a_reg),
    .b      (b_reg),
    .op     (op_reg),
    .result (result)
  );

`ifdef MDU_DIV0_GUARD_EN
  assign commit_ok = !(is_div(op_reg) && (b_reg == 32'd0));
`else
  assign commit_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      op_reg    <= MDU_DIV;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          // An accepted start takes priority over MTHI/MTLO in the same cycle.
          a_next     = rs_data;
          b_next     = rt_data;
          op_next    = mdu_op_e'(op);
          cnt_next   = op[1] ? MULT_LOAD : DIV_LOAD;
          state_next = RUN;
        end else begin
          if (mthi_we) hi_next = wdata;
          if (mtlo_we) lo_next = wdata;
        end
      end
      RUN: begin
        if (flush) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          if (commit_ok) begin
            hi_next = result[63:32];
            lo_next = result[31:0];
          end
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

`ifndef SYNTHESIS
  // Upstream hazard logic must stall issue while an operation is in flight.
  start_while_busy_a : assert property (
    @(posedge clk) disable iff (!rst_n) !(start && (state_reg == RUN))
  );
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO, a monitor
// checks them whenever done pulses.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .wdata   (wdata),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge of the done cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input string name);
    int n;
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.name = name;
    exp_q.push_back(e);
    start = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 32'(n), 32'(lat));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 required done=0 (hi=%h lo=%h)", hi, lo);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " hi"}, hi, e.hi);
          check({e.name, " lo"}, lo, e.lo);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    rs_data = 32'd0;
    rt_data = 32'd0;
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    wdata = 32'd0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst_n = 1'b1;

    // Consecutive issues land on the done cycle, exercising back-to-back start.
    issue(2'b10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult -2*3");
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, "multu max*max");
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div -7/2");
    issue(2'b01, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu 7/2");
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, "div 7/-2");

    // mthi alongside start is dropped, and stays ignored while running.
    mthi_we = 1'b1;
    wdata = 32'h5555;
    issue(2'b10, 32'd2, 32'd3, 32'd0, 32'd6, 5, "mult 2*3 with mthi");
    mthi_we = 1'b0;

    // MTHI/MTLO then a flushed mult.
    mthi_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    mthi_we = 1'b0;
    mtlo_we = 1'b1;
    wdata = 32'd0;
    @(negedge clk);
    mtlo_we = 1'b0;
    start = 1'b1;
    op = 2'b10;
    rs_data = 32'd2;
    rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    repeat (8) @(negedge clk);
    check("flush hi", hi, 32'h1234);
    check("flush lo", lo, 32'd0);

    // Start with flush is ignored, but the MTHI in the same cycle still lands.
    start = 1'b1;
    flush = 1'b1;
    mthi_we = 1'b1;
    wdata = 32'h77;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    mthi_we = 1'b0;
    check("start+flush busy", 32'(busy), 32'd0);
    check("start+flush hi", hi, 32'h77);

    // Both write enables together.
    mthi_we = 1'b1;
    mtlo_we = 1'b1;
    wdata = 32'hAA;
    @(negedge clk);
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    check("mthi+mtlo hi", hi, 32'hAA);
    check("mthi+mtlo lo", lo, 32'hAA);

`ifdef MDU_DIV0_GUARD_EN
    issue(2'b01, 32'd5, 32'd0, 32'hAA, 32'hAA, 10, "divu by zero guarded");
`endif

    // Reset in the middle of a divide.
    start = 1'b1;
    op = 2'b00;
    rs_data = 32'd100;
    rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset hi", hi, 32'd0);
    check("midrun reset lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    issue(2'b10, 32'd2, 32'd3, 32'd0, 32'd6, 5, "mult after reset");

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
